ws_result_collector: RTL and testbench
======================================

WS_RESULT_COLLECTOR -- requirements
Module: ws_result_collector

Interface
REQ-001 Parameter out_word_size, default 16: width of each result word.
REQ-002 Parameter row, default 3: number of array rows (result lanes); SHALL be at least 1.
REQ-003 Parameter depth, default 4: number of vector entries in the output FIFO; SHALL be a power of 2 and at least 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 Result_in  input  out_word_size x [0:row-1]  skewed result lanes from the systolic array.
REQ-007 in_valid  input  1  marks cycle t in which lane 0 of a vector is present; lane r of the same vector is present at cycle t+r.
REQ-008 clear_err  input  1  synchronous clear of overflow_err.
REQ-009 out_data  output  out_word_size x [0:row-1]  aligned vector at the FIFO head.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  consumer accepts head when high with out_valid.
REQ-012 count  output  $clog2(depth+1)  stored vector count.
REQ-013 full, empty  output  1 each  FIFO status.
REQ-014 overflow_err  output  1  sticky drop indicator.

Function
REQ-015 Lane r SHALL pass through (row-1-r) pipeline registers, so lane row-1 is unregistered and lane 0 has row-1 stages.
REQ-016 in_valid SHALL pass through a row-1 stage valid pipeline aligned with lane 0.
REQ-017 When the delayed valid is high, the aligned vector SHALL be pushed at that cycle's clock edge; for in_valid at cycle t, out_valid SHALL rise in cycle t+row if the FIFO was empty.
REQ-018 in_valid in consecutive cycles SHALL yield consecutive pushes; no input backpressure exists.
REQ-019 Pop SHALL occur on an edge where out_valid and out_ready are both high; the head then advances.
REQ-020 out_data SHALL show the head entry combinationally (show-ahead), held stable while out_valid high and out_ready low.
REQ-021 out_data SHALL be all zeros when empty.
REQ-022 Push and pop in the same cycle SHALL both occur; count unchanged, including when full.
REQ-023 Push when full without a simultaneous pop SHALL drop the vector, leave FIFO contents and count unchanged, and set overflow_err on the next edge.
REQ-024 overflow_err SHALL stay high until clear_err is sampled high or reset; clear_err and a new overflow in the same cycle SHALL leave overflow_err high.
REQ-025 Pop when empty SHALL have no effect.
REQ-026 full SHALL equal (count==depth); empty SHALL equal (count==0); out_valid SHALL equal !empty.
REQ-027 Read/write pointers SHALL wrap modulo depth with no lost or duplicated entry.
REQ-028 Words SHALL be stored and output unmodified; no arithmetic on data.

Reset
REQ-029 rst low SHALL immediately clear count to 0, empty 1, full 0, out_valid 0, out_data 0, overflow_err 0, pointers 0, all deskew and valid-pipeline registers 0.
REQ-030 Vectors in flight in the deskew pipeline at reset SHALL be discarded; no push SHALL result from them after rst is released.
REQ-031 After rst rises, the first in_valid SHALL behave per REQ-017.

Verification (row=3, depth=4, out_word_size=16)
REQ-032 in_valid at cycle 0 with lanes 0x11 (c0), 0x22 (c1), 0x33 (c2), out_ready=1 -> out_valid high in cycle 3 only, out_data={0x11,0x22,0x33}.
REQ-033 Back-to-back in_valid cycles 0-3 with out_ready=0 -> count reaches 4, full=1, vectors read in order after out_ready=1; pointers wrap on 5th-8th vectors with order preserved.
REQ-034 FIFO full, 5th vector arrives with out_ready=0 -> vector dropped, count stays 4, overflow_err=1 until clear_err pulse.
REQ-035 FIFO full, 5th vector arrives with out_ready=1 in the push cycle -> count stays 4, no overflow_err, 5th vector is last out.
REQ-036 rst asserted at cycle 1 after in_valid at cycle 0 -> outputs zero immediately; after release no out_valid from that vector.
REQ-037 out_ready=0 with out_valid=1 for 5 cycles -> out_data unchanged across all 5 cycles.

Source files
------------

// File: rtl/ws_result_collector.sv
// Deskews the diagonal result lanes of a weight-stationary systolic array and
// queues each aligned result vector in a show-ahead FIFO with overflow tracking.
module ws_result_collector #(
  parameter int out_word_size = 16,
  parameter int row           = 3,
  parameter int depth         = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [out_word_size-1:0]               Result_in [0:row-1],
  input  logic                                   in_valid,
  input  logic                                   clear_err,
  output logic [out_word_size-1:0]               out_data  [0:row-1],
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(depth+1)-1:0]             count,
  output logic                                   full,
  output logic                                   empty,
  output logic                                   overflow_err
);

  localparam int unsigned W  = out_word_size;
  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = $clog2(depth+1);

  logic [W-1:0]  aligned [0:row-1];
  logic          dv;

  // Lane r waits (row-1-r) cycles so every lane lines up with lane 0.
  for (genvar r = 0; r < row; r++) begin : g_lane
    localparam int STG = row - 1 - r;
    if (STG == 0) begin : g_pass
      assign aligned[r] = Result_in[r];
    end else begin : g_dly
      logic [W-1:0] dly_q [STG];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < STG; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= Result_in[r];
          for (int i = 1; i < STG; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign aligned[r] = dly_q[STG-1];
    end
  end

  // Valid travels alongside lane 0.
  if (row == 1) begin : g_vld_pass
    assign dv = in_valid;
  end else begin : g_vld_dly
    logic [row-2:0] vld_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= in_valid;
        for (int i = 1; i < row - 1; i++) vld_q[i] <= vld_q[i-1];
      end
    end
    assign dv = vld_q[row-2];
  end

  logic [W-1:0]  mem_q [depth][row];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push_c, pop_c, full_c, empty_c;

  assign full_c  = (count_q == CW'(depth));
  assign empty_c = (count_q == '0);
  assign pop_c   = !empty_c && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_c  = dv && (!full_c || pop_c);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_c && !pop_c)      count_d = count_q + CW'(1);
    else if (!push_c && pop_c) count_d = count_q - CW'(1);
    if (dv && !push_c)  ovf_d = 1'b1;
    else if (clear_err) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_c) begin
      for (int r = 0; r < row; r++) mem_q[wr_ptr_q][r] <= aligned[r];
    end
  end

  always_comb begin
    for (int r = 0; r < row; r++) begin
      out_data[r] = empty_c ? '0 : mem_q[rd_ptr_q][r];
    end
  end

  assign out_valid    = !empty_c;
  assign count        = count_q;
  assign full         = full_c;
  assign empty        = empty_c;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_ws_result_collector.sv
// Directed bench for ws_result_collector: a queue model driven from the raw
// input history is checked every cycle, plus literal spot checks.
module tb_ws_result_collector;

  localparam int W     = 16;
  localparam int ROW   = 3;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int H     = 8;

  typedef logic [ROW-1:0][W-1:0] pvec_t;

  logic          clk;
  logic          rst;
  logic [W-1:0]  Result_in [ROW];
  logic          in_valid;
  logic          clear_err;
  logic [W-1:0]  out_data [ROW];
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow_err;

  ws_result_collector #(.out_word_size(W), .row(ROW), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .Result_in(Result_in), .in_valid(in_valid),
    .clear_err(clear_err), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .full(full), .empty(empty),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] pat(int k, int r);
    return W'((k << 8) | ((r + 1) * 17));
  endfunction

  // Model: remember what arrived on each lane; a vector started at cycle t is
  // lane r taken from cycle t+r, and it enters the queue at the end of t+row-1.
  pvec_t        mq[$];
  bit           movf;
  bit           hv [H];
  logic [W-1:0] hd [H][ROW];
  int           mcyc = 0;
  bit           m_pop, m_push, m_full;
  pvec_t        m_vec;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      movf = 1'b0;
      for (int i = 0; i < H; i++) hv[i] = 1'b0;
    end else begin
      mcyc++;
      hv[mcyc % H] = in_valid;
      for (int r = 0; r < ROW; r++) hd[mcyc % H][r] = Result_in[r];
      m_push = hv[(mcyc + H - (ROW - 1)) % H];
      for (int r = 0; r < ROW; r++) m_vec[r] = hd[(mcyc + H - (ROW - 1) + r) % H][r];
      m_pop  = (mq.size() > 0) && out_ready;
      m_full = (mq.size() == DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (m_push && (!m_full || m_pop)) mq.push_back(m_vec);
      if (m_push && m_full && !m_pop) movf = 1'b1;
      else if (clear_err)             movf = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(mq.size() > 0));
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("overflow_err", int'(overflow_err), int'(movf));
    for (int r = 0; r < ROW; r++)
      chk($sformatf("out_data[%0d]", r), int'(out_data[r]),
          (mq.size() > 0) ? int'(mq[0][r]) : 0);
  end

  // Stimulus: lid[c] is the vector id launched in cycle c (-1 if none).
  int lid [1024];
  int scur = 0;

  task automatic step(input bit iv, input int id, input bit rdy, input bit clr);
    @(posedge clk);
    #1;
    scur++;
    lid[scur] = iv ? id : -1;
    in_valid  = iv;
    out_ready = rdy;
    clear_err = clr;
    for (int r = 0; r < ROW; r++) begin
      if (scur - r >= 0 && lid[scur - r] >= 0) Result_in[r] = pat(lid[scur - r], r);
      else                                     Result_in[r] = W'($urandom);
    end
  endtask

  task automatic idle(input int n, input bit rdy, input bit clr);
    for (int i = 0; i < n; i++) step(1'b0, 0, rdy, clr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) lid[i] = -1;
    rst = 1'b0;
    in_valid = 1'b0;
    clear_err = 1'b0;
    out_ready = 1'b0;
    for (int r = 0; r < ROW; r++) Result_in[r] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    chk("reset count", int'(count), 0);
    chk("reset empty", int'(empty), 1);
    chk("reset full", int'(full), 0);
    chk("reset ovf", int'(overflow_err), 0);

    // Single vector, consumer always ready: visible in cycle t+3 only.
    step(1'b1, 0, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);
    @(negedge clk);
    chk("single early valid", int'(out_valid), 0);
    idle(1, 1'b1, 1'b0);
    @(negedge clk);
    chk("single valid", int'(out_valid), 1);
    chk("single lane0", int'(out_data[0]), 'h11);
    chk("single lane1", int'(out_data[1]), 'h22);
    chk("single lane2", int'(out_data[2]), 'h33);
    idle(1, 1'b1, 1'b0);
    @(negedge clk);
    chk("single gone", int'(out_valid), 0);

    // Fill with back-to-back vectors, then hold the head for 5 cycles.
    for (int k = 1; k <= 4; k++) step(1'b1, k, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    @(negedge clk);
    chk("fill count", int'(count), 4);
    chk("fill full", int'(full), 1);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b0, 1'b0);
      @(negedge clk);
      chk("hold lane0", int'(out_data[0]), int'(pat(1, 0)));
      chk("hold lane2", int'(out_data[2]), int'(pat(1, 2)));
    end

    // Overflow while full and stalled.
    step(1'b1, 5, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    @(negedge clk);
    chk("drop count", int'(count), 4);
    chk("drop ovf", int'(overflow_err), 1);
    // Clear coincides with a new drop: flag must stay set.
    step(1'b1, 6, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    idle(1, 1'b0, 1'b0);
    @(negedge clk);
    chk("clear vs drop ovf", int'(overflow_err), 1);
    idle(1, 1'b0, 1'b1);
    idle(1, 1'b0, 1'b0);
    @(negedge clk);
    chk("cleared ovf", int'(overflow_err), 0);

    // Drain in order.
    idle(1, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain head", int'(out_data[1]), int'(pat(1, 1)));
    idle(4, 1'b1, 1'b0);

    // Wrap pointers; the 5th vector lands on an edge that also pops.
    for (int k = 7; k <= 10; k++) step(1'b1, k, 1'b0, 1'b0);
    step(1'b1, 11, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);
    @(negedge clk);
    chk("push+pop count", int'(count), 4);
    chk("push+pop ovf", int'(overflow_err), 0);
    chk("push+pop head", int'(out_data[0]), int'(pat(8, 0)));
    idle(6, 1'b1, 1'b0);

    // Reset with a vector in flight.
    step(1'b1, 40, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rst count", int'(count), 0);
    chk("rst empty", int'(empty), 1);
    chk("rst valid", int'(out_valid), 0);
    chk("rst data", int'(out_data[0]), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b1, 1'b0);
      @(negedge clk);
      chk("post-rst valid", int'(out_valid), 0);
    end

    // Mixed traffic with intermittent backpressure.
    for (int i = 0; i < 24; i++) step((i % 3) != 1, 50 + i, (i % 4) != 0, 1'b0);
    idle(8, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
